// File: rtl/shim_trigger_waiter.sv
// shim_trigger_waiter: channel-side trigger-sync waiter; optional cycle timestamps via SHIM_TRIGGER_WAITER_TIMESTAMP_EN
module shim_trigger_waiter #(
    parameter int COUNT_WIDTH   = 16,
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic                     arm_valid_i,
    output logic                     arm_ready_o,
    input  logic [COUNT_WIDTH-1:0]   arm_count_i,
    input  logic                     cancel_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles_i,
    input  logic                     trigger_in_i,
    output logic                     waiting_for_trigger_o,
    output logic                     release_o,
    output logic [COUNT_WIDTH-1:0]   remaining_o,
    output logic                     unexpected_trig_o,
    output logic                     timeout_err_o,
    output logic [31:0]              trig_timestamp_o,
    output logic                     trig_timestamp_valid_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERROR} state_e;

    state_e                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic                     waiting_q, waiting_d;
    logic                     release_q, release_d;
    logic                     unexp_q, unexp_d;
    logic                     terr_q, terr_d;
    logic                     accept, count_trig, last_trig, expired;
    logic [TIMEOUT_WIDTH:0]   tmo_inc;

    // cancel beats a same-cycle trigger; a trigger beats a same-cycle timeout expiry
    assign accept     = arm_valid_i && (state_q == S_IDLE);
    assign count_trig = (state_q == S_WAIT) && trigger_in_i && !cancel_i;
    assign last_trig  = count_trig && (remaining_q <= COUNT_WIDTH'(1));
    assign tmo_inc    = {1'b0, tmo_q} + (TIMEOUT_WIDTH+1)'(1);
    assign expired    = (state_q == S_WAIT) && !trigger_in_i && !cancel_i &&
                        (timeout_cycles_i != '0) && (tmo_inc >= {1'b0, timeout_cycles_i});

    // state register
    always_ff @(posedge clk_i) begin
        if (!resetn_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // next-state logic; S_ERROR is only left through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (accept && arm_count_i != '0) ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = (cancel_i || last_trig) ? S_IDLE : expired ? S_ERROR : S_WAIT;
            default: state_d = S_ERROR;
        endcase
    end

    // next values of registered outputs, counters and sticky flags
    always_comb begin
        waiting_d   = (state_d == S_WAIT);
        release_d   = (accept && arm_count_i == '0) || last_trig;
        unexp_d     = unexp_q || (trigger_in_i && state_q != S_WAIT);
        terr_d      = terr_q || (state_q == S_WAIT && state_d == S_ERROR);
        remaining_d = accept ? arm_count_i :
                      (state_d != S_WAIT) ? '0 :
                      (count_trig && remaining_q != '0) ? remaining_q - COUNT_WIDTH'(1) : remaining_q;
        tmo_d       = (state_q != S_WAIT || state_d != S_WAIT || count_trig) ? '0 :
                      (&tmo_q) ? tmo_q : tmo_q + TIMEOUT_WIDTH'(1);
    end

    // output and counter registers
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            remaining_q <= '0;
            tmo_q       <= '0;
            waiting_q   <= 1'b0;
            release_q   <= 1'b0;
            unexp_q     <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            tmo_q       <= tmo_d;
            waiting_q   <= waiting_d;
            release_q   <= release_d;
            unexp_q     <= unexp_d;
            terr_q      <= terr_d;
        end
    end

    assign arm_ready_o           = (state_q == S_IDLE);
    assign waiting_for_trigger_o = waiting_q;
    assign release_o             = release_q;
    assign remaining_o           = remaining_q;
    assign unexpected_trig_o     = unexp_q;
    assign timeout_err_o         = terr_q;

`ifdef SHIM_TRIGGER_WAITER_TIMESTAMP_EN
    logic [31:0] cyc_q, ts_q;
    logic        ts_valid_q;

    // free-running cycle counter, captured on every counted trigger
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cyc_q      <= '0;
            ts_q       <= '0;
            ts_valid_q <= 1'b0;
        end else begin
            cyc_q      <= cyc_q + 32'd1;
            ts_valid_q <= count_trig;
            if (count_trig) ts_q <= cyc_q;
        end
    end

    assign trig_timestamp_o       = ts_q;
    assign trig_timestamp_valid_o = ts_valid_q;
`else
    assign trig_timestamp_o       = '0;
    assign trig_timestamp_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_shim_trigger_waiter.sv
// tb_shim_trigger_waiter: directed bench with a release-event scoreboard
module tb_shim_trigger_waiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        arm_valid = 1'b0;
    logic        arm_ready;
    logic [15:0] arm_count = '0;
    logic        cancel = 1'b0;
    logic [31:0] timeout_cycles = '0;
    logic        trigger_in = 1'b0;
    logic        waiting, release_p, unexp, terr, ts_valid;
    logic [15:0] remaining;
    logic [31:0] ts;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tcnt = 0;
    int ts_exp = 0;
    int exp_q[$];

    shim_trigger_waiter dut (
        .clk_i(clk), .resetn_i(resetn), .arm_valid_i(arm_valid), .arm_ready_o(arm_ready),
        .arm_count_i(arm_count), .cancel_i(cancel), .timeout_cycles_i(timeout_cycles),
        .trigger_in_i(trigger_in), .waiting_for_trigger_o(waiting), .release_o(release_p),
        .remaining_o(remaining), .unexpected_trig_o(unexp), .timeout_err_o(terr),
        .trig_timestamp_o(ts), .trig_timestamp_valid_o(ts_valid)
    );

    always #5 clk = ~clk;

    // cycle index for release timing and the reference cycle counter for timestamps
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tcnt <= resetn ? tcnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // every observed release pulse must match the next expected release cycle
    always @(negedge clk) begin
        if (resetn && release_p) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL release_unexpected: pulse at cycle %0d with none expected", cyc);
            end else chk("release_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic rdy, input logic w, input logic [15:0] rem);
        chk({tag, "_arm_ready"}, {31'd0, arm_ready}, {31'd0, rdy});
        chk({tag, "_waiting"}, {31'd0, waiting}, {31'd0, w});
        chk({tag, "_remaining"}, {16'd0, remaining}, {16'd0, rem});
    endtask

    task automatic arm(input logic [15:0] n);
        arm_valid = 1'b1;
        arm_count = n;
        if (n == 0) exp_q.push_back(cyc + 1);
        tick();
        arm_valid = 1'b0;
    endtask

    task automatic trig(input logic last);
        if (last) exp_q.push_back(cyc + 1);
        ts_exp = tcnt;
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
`ifdef SHIM_TRIGGER_WAITER_TIMESTAMP_EN
        chk("ts_valid", {31'd0, ts_valid}, 32'd1);
        chk("ts_value", ts, ts_exp);
`else
        chk("ts_valid", {31'd0, ts_valid}, 32'd0);
        chk("ts_value", ts, 32'd0);
`endif
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            tick();
            chk("waiting_hold", {31'd0, waiting}, 32'd1);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        st("reset", 1'b1, 1'b0, 16'd0);
        chk("reset_release", {31'd0, release_p}, 32'd0);
        chk("reset_unexp", {31'd0, unexp}, 32'd0);
        chk("reset_terr", {31'd0, terr}, 32'd0);
        chk("reset_ts", ts, 32'd0);

        // three-trigger wait
        arm(16'd3);
        st("arm3", 1'b0, 1'b1, 16'd3);
        hold(4);
        trig(1'b0);
        st("trig1", 1'b0, 1'b1, 16'd2);
        hold(14);
        trig(1'b0);
        st("trig2", 1'b0, 1'b1, 16'd1);
        hold(19);
        trig(1'b1);
        st("trig3", 1'b1, 1'b0, 16'd0);
        chk("trig3_release", {31'd0, release_p}, 32'd1);
        tick();
        chk("release_one_cycle", {31'd0, release_p}, 32'd0);

        // zero-count arm releases immediately
        arm(16'd0);
        st("arm0", 1'b1, 1'b0, 16'd0);
        chk("arm0_release", {31'd0, release_p}, 32'd1);
        tick();
        st("arm0_after", 1'b1, 1'b0, 16'd0);

        // cancel collides with a trigger
        arm(16'd2);
        tick();
        cancel = 1'b1;
        trigger_in = 1'b1;
        tick();
        cancel = 1'b0;
        trigger_in = 1'b0;
        st("cancel", 1'b1, 1'b0, 16'd0);
        chk("cancel_unexp", {31'd0, unexp}, 32'd0);
        repeat (3) tick();

        // stray trigger in idle, then a normal single wait with arm held during release
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        chk("idle_trig_unexp", {31'd0, unexp}, 32'd1);
        arm(16'd1);
        st("arm1", 1'b0, 1'b1, 16'd1);
        arm_valid = 1'b1;
        arm_count = 16'd5;
        trig(1'b1);
        st("release_arm_ignored", 1'b1, 1'b0, 16'd0);
        arm_valid = 1'b0;
        tick();
        st("after_ignored_arm", 1'b1, 1'b0, 16'd0);

        // trigger on the expiry cycle is counted and restarts the timeout
        do_reset();
        timeout_cycles = 32'd10;
        arm(16'd2);
        repeat (9) tick();
        chk("pre_expiry_terr", {31'd0, terr}, 32'd0);
        trig(1'b0);
        st("expiry_trig", 1'b0, 1'b1, 16'd1);
        chk("expiry_trig_terr", {31'd0, terr}, 32'd0);
        repeat (5) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        st("cancel2", 1'b1, 1'b0, 16'd0);

        // timeout with no trigger
        arm(16'd1);
        repeat (9) tick();
        chk("tmo_edge_terr", {31'd0, terr}, 32'd0);
        chk("tmo_edge_waiting", {31'd0, waiting}, 32'd1);
        tick();
        chk("tmo_terr", {31'd0, terr}, 32'd1);
        st("tmo_err_state", 1'b0, 1'b0, 16'd0);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        chk("err_trig_unexp", {31'd0, unexp}, 32'd1);
        arm_valid = 1'b1;
        arm_count = 16'd1;
        cancel = 1'b1;
        repeat (3) tick();
        arm_valid = 1'b0;
        cancel = 1'b0;
        st("err_stuck", 1'b0, 1'b0, 16'd0);
        chk("err_stuck_terr", {31'd0, terr}, 32'd1);
        do_reset();
        st("err_reset", 1'b1, 1'b0, 16'd0);
        chk("err_reset_terr", {31'd0, terr}, 32'd0);
        chk("err_reset_unexp", {31'd0, unexp}, 32'd0);

        // trigger counted at cycle 100 after reset
        timeout_cycles = 32'd0;
        arm(16'd1);
        while (tcnt < 100) tick();
        trig(1'b1);
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL release_missing: %0d expected pulses not seen", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
